// File: rtl/fifo_arbiter.sv
// Four-to-one scheduler draining four class FIFOs into one egress FIFO.
// Define FIFO_ARB_STRICT_PRIO_EN for strict lowest-index priority instead of round-robin.
module fifo_arbiter #(
  parameter int tamano_datos = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                in_empty,
  input  logic [3:0]                in_almost_empty,
  input  logic [3:0]                in_error,
  input  logic [4*tamano_datos-1:0] in_data,
  output logic [3:0]                in_read_enable,
  input  logic                      out_full,
  input  logic                      out_almost_full,
  output logic                      out_write_enable,
  output logic [tamano_datos-1:0]   out_data,
  output logic [1:0]                grant,
  output logic [1:0]                state,
  output logic                      error
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b10,
    ERR    = 2'b11
  } state_t;

  state_t     state_q, nxt;
  logic [1:0] last;
  logic [1:0] grant_d;
  logic       pop_d;
  logic [3:0] eligible;
  logic       any_elig;
  logic       err_cond;
  logic [1:0] sel;
  logic [1:0] idx;

  // A FIFO whose last word is being popped right now must not be popped again.
  always_comb begin
    eligible = ~in_empty & ~(in_almost_empty & in_read_enable);
    any_elig = |eligible;
    err_cond = (|in_error) | (out_full & (pop_d | out_write_enable));
  end

`ifdef FIFO_ARB_STRICT_PRIO_EN
  always_comb begin
    sel = 2'd0;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) sel = 2'(i);
    end
  end
`else
  // Walk last+4 down to last+1 so the nearest eligible index after last wins.
  always_comb begin
    sel = last;
    idx = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (eligible[idx]) sel = idx;
    end
  end
`endif

  always_comb begin
    nxt = state_q;
    case (state_q)
      IDLE:    if (any_elig) nxt = out_almost_full ? HOLD : ACTIVE;
      ACTIVE:  if (out_almost_full) nxt = HOLD;
               else if (!any_elig) nxt = IDLE;
      HOLD:    if (!out_almost_full) nxt = any_elig ? ACTIVE : IDLE;
      default: nxt = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      in_read_enable   <= 4'b0000;
      grant            <= 2'd0;
      grant_d          <= 2'd0;
      last             <= 2'd3;
      pop_d            <= 1'b0;
      out_write_enable <= 1'b0;
      out_data         <= '0;
      error            <= 1'b0;
    end else if (err_cond || state_q == ERR) begin
      // Error is sticky until reset; words still in the pipe are discarded.
      state_q          <= ERR;
      error            <= 1'b1;
      in_read_enable   <= 4'b0000;
      pop_d            <= 1'b0;
      out_write_enable <= 1'b0;
    end else begin
      state_q <= nxt;
      if (nxt == ACTIVE) begin
        in_read_enable <= 4'b0001 << sel;
        grant          <= sel;
        last           <= sel;
      end else begin
        in_read_enable <= 4'b0000;
      end
      pop_d            <= |in_read_enable;
      grant_d          <= grant;
      out_write_enable <= pop_d;
      if (pop_d) out_data <= in_data[grant_d*tamano_datos +: tamano_datos];
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a small registered-FIFO model on each input.
module tb_fifo_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_empty;
  logic [3:0]  in_almost_empty;
  logic [3:0]  in_error;
  logic [39:0] in_data = '0;
  logic [3:0]  in_read_enable;
  logic        out_full;
  logic        out_almost_full;
  logic        out_write_enable;
  logic [9:0]  out_data;
  logic [1:0]  grant;
  logic [1:0]  state;
  logic        error;

  int checks = 0;
  int failures = 0;

  fifo_arbiter #(.tamano_datos(10)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_empty         (in_empty),
    .in_almost_empty  (in_almost_empty),
    .in_error         (in_error),
    .in_data          (in_data),
    .in_read_enable   (in_read_enable),
    .out_full         (out_full),
    .out_almost_full  (out_almost_full),
    .out_write_enable (out_write_enable),
    .out_data         (out_data),
    .grant            (grant),
    .state            (state),
    .error            (error)
  );

  always #5 clk = ~clk;

  // Input FIFO model: pop on the strobe seen at the edge, data and flags registered.
  logic [9:0] mem [4][32];
  int wp [4] = '{0, 0, 0, 0};
  int rp [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int sz;
      if (in_read_enable[i] === 1'b1 && rp[i] < wp[i]) begin
        in_data[i*10 +: 10] <= mem[i][rp[i]];
        rp[i] = rp[i] + 1;
      end
      sz = wp[i] - rp[i];
      in_empty[i]        <= (sz == 0);
      in_almost_empty[i] <= (sz <= 1);
    end
  end

  task automatic load(input int f, input logic [9:0] w);
    mem[f][wp[f]] = w;
    wp[f] = wp[f] + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [1:0] g2 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [9:0] d2 [8] = '{10'h091, 10'h093, 10'h0B5, 10'h1E5, 10'h04A, 10'h046, 10'h164, 10'h266};
`ifdef FIFO_ARB_STRICT_PRIO_EN
  logic [1:0] g6 [4] = '{2'd0, 2'd0, 2'd3, 2'd3};
`else
  logic [1:0] g6 [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
`endif

  initial begin
    reset = 1'b1;
    in_error = 4'b0000;
    out_full = 1'b0;
    out_almost_full = 1'b0;
    repeat (4) step();
    chk("rst_rd", 32'(in_read_enable), 32'h0);
    chk("rst_we", 32'(out_write_enable), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    reset = 1'b0;

    // Two words per FIFO: strict rotation, pushes start two cycles after first pop.
    load(0, 10'h091); load(0, 10'h04A);
    load(1, 10'h093); load(1, 10'h046);
    load(2, 10'h0B5); load(2, 10'h164);
    load(3, 10'h1E5); load(3, 10'h266);
    step();
    chk("rr_idle", 32'(state), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_rd", 32'(in_read_enable), 32'(4'b0001 << g2[k]));
      chk("rr_grant", 32'(grant), 32'(g2[k]));
      chk("rr_state", 32'(state), 32'h1);
      if (k >= 2) begin
        chk("rr_we", 32'(out_write_enable), 32'h1);
        chk("rr_data", 32'(out_data), 32'(d2[k-2]));
      end else begin
        chk("rr_we0", 32'(out_write_enable), 32'h0);
      end
    end
    step();
    chk("rr_end_state", 32'(state), 32'h0);
    chk("rr_end_rd", 32'(in_read_enable), 32'h0);
    chk("rr_data6", 32'(out_data), 32'(d2[6]));
    step();
    chk("rr_data7", 32'(out_data), 32'(d2[7]));
    chk("rr_we7", 32'(out_write_enable), 32'h1);
    step();
    chk("rr_we_off", 32'(out_write_enable), 32'h0);

    // Single word in FIFO 2: one pop, then a gap and back to IDLE.
    load(2, 10'h123);
    step();
    step();
    chk("one_rd", 32'(in_read_enable), 32'h4);
    chk("one_grant", 32'(grant), 32'h2);
    step();
    chk("one_no_second_pop", 32'(in_read_enable), 32'h0);
    chk("one_idle", 32'(state), 32'h0);
    step();
    chk("one_we", 32'(out_write_enable), 32'h1);
    chk("one_data", 32'(out_data), 32'h123);
    step();
    chk("one_we_off", 32'(out_write_enable), 32'h0);

    // Back-pressure during streaming.
    load(0, 10'h011); load(0, 10'h012);
    load(1, 10'h021); load(1, 10'h022);
    load(2, 10'h031); load(2, 10'h032);
    load(3, 10'h041); load(3, 10'h042);
    step();
    step();
    chk("af_g3", 32'(grant), 32'h3);
    step();
    chk("af_g0", 32'(grant), 32'h0);
    out_almost_full = 1'b1;
    step();
    chk("af_hold", 32'(state), 32'h2);
    chk("af_rd0", 32'(in_read_enable), 32'h0);
    chk("af_push1", 32'(out_data), 32'h041);
    chk("af_we1", 32'(out_write_enable), 32'h1);
    step();
    chk("af_push2", 32'(out_data), 32'h011);
    chk("af_rd1", 32'(in_read_enable), 32'h0);
    step();
    chk("af_we_off", 32'(out_write_enable), 32'h0);
    chk("af_still_hold", 32'(state), 32'h2);
    out_almost_full = 1'b0;
    step();
    chk("af_resume_state", 32'(state), 32'h1);
    chk("af_resume_grant", 32'(grant), 32'h1);
    repeat (10) step();
    chk("af_drain_idle", 32'(state), 32'h0);
    chk("af_drain_empty", 32'(in_empty), 32'hF);

    // Error pulse, then reset recovery and reset mid-transfer.
    load(1, 10'h0A1); load(1, 10'h0A2); load(1, 10'h0A3);
    step();
    step();
    chk("err_pre_grant", 32'(grant), 32'h1);
    in_error = 4'b0010;
    step();
    chk("err_flag", 32'(error), 32'h1);
    chk("err_state", 32'(state), 32'h3);
    chk("err_rd", 32'(in_read_enable), 32'h0);
    in_error = 4'b0000;
    load(3, 10'h0B1); load(3, 10'h0B2);
    step();
    chk("err_sticky", 32'(error), 32'h1);
    chk("err_dropped_we", 32'(out_write_enable), 32'h0);
    step();
    chk("err_rd2", 32'(in_read_enable), 32'h0);
    chk("err_state2", 32'(state), 32'h3);
    reset = 1'b1;
    step();
    chk("err_rst_error", 32'(error), 32'h0);
    chk("err_rst_state", 32'(state), 32'h0);
    reset = 1'b0;
    step();
    chk("ptr_reset_grant", 32'(grant), 32'h1);
    chk("ptr_reset_rd", 32'(in_read_enable), 32'h2);
    reset = 1'b1;
    step();
    chk("mid_rst_rd", 32'(in_read_enable), 32'h0);
    chk("mid_rst_state", 32'(state), 32'h0);
    step();
    chk("mid_rst_we", 32'(out_write_enable), 32'h0);
    reset = 1'b0;
    repeat (10) step();
    chk("mid_rst_drain", 32'(state), 32'h0);

    // FIFOs 0 and 3 loaded from a fresh pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    load(0, 10'h0C1); load(0, 10'h0C2);
    load(3, 10'h0D1); load(3, 10'h0D2);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("prio_grant", 32'(grant), 32'(g6[k]));
      chk("prio_rd", 32'(in_read_enable), 32'(4'b0001 << g6[k]));
    end
    step();
    chk("prio_idle", 32'(state), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
